// File: rtl/exec_adder.sv
// rtl/exec_adder.sv - integer adder functional unit feeding the common data bus
// Accepts one ready instruction, executes for LATENCY cycles, then holds the result until granted.

`ifndef DEVICE_ADDER
`define DEVICE_ADDER 3'd1
`endif
`ifndef ADDER_ALGO_ADD
`define ADDER_ALGO_ADD 2'b00
`endif
`ifndef ADDER_ALGO_SUB
`define ADDER_ALGO_SUB 2'b01
`endif
`ifndef ADDER_ALGO_SLT
`define ADDER_ALGO_SLT 2'b10
`endif
`ifndef ADDER_ALGO_SLTU
`define ADDER_ALGO_SLTU 2'b11
`endif

module exec_adder #(
  parameter int         LATENCY   = 2,
  parameter logic [2:0] DEVICE_ID = `DEVICE_ADDER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_buzy,
  input  logic        in_ready,
  input  logic [1:0]  in_algorithm,
  input  logic [35:0] in_valueA,
  input  logic [35:0] in_valueB,
  output logic        nxt_buzy,
  input  logic        cdb_grant,
  output logic        cdb_req,
  output logic [2:0]  cdb_req_device,
  output logic [31:0] cdb_req_value
);

  localparam logic [3:0] LP_CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EXEC     = 2'd1,
    S_WAIT_CDB = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [1:0]  r_alg;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_result;
  logic        r_nxt_buzy;
  logic        r_cdb_req;

  logic [32:0] w_sub33;
  logic        w_lt_signed;
  logic        w_lt_unsigned;
  logic [31:0] w_result;
  logic        w_unused_tags;

  assign w_unused_tags = ^{in_valueA[35:32], in_valueB[35:32]};

  // One 33-bit subtract yields the difference, the unsigned borrow and the signed compare.
  assign w_sub33       = {1'b0, r_a} - {1'b0, r_b};
  assign w_lt_unsigned = w_sub33[32];
  assign w_lt_signed   = (r_a[31] != r_b[31]) ? r_a[31] : w_sub33[31];

  always_comb begin
    w_result = 32'd0;
    case (r_alg)
      `ADDER_ALGO_ADD:  w_result = r_a + r_b;
      `ADDER_ALGO_SUB:  w_result = w_sub33[31:0];
      `ADDER_ALGO_SLT:  w_result = {31'd0, w_lt_signed};
      `ADDER_ALGO_SLTU: w_result = {31'd0, w_lt_unsigned};
      default:          w_result = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_alg      <= 2'd0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_result   <= 32'd0;
      r_nxt_buzy <= 1'b0;
      r_cdb_req  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_buzy && in_ready) begin
            r_alg      <= in_algorithm;
            r_a        <= in_valueA[31:0];
            r_b        <= in_valueB[31:0];
            r_cnt      <= LP_CNT_INIT;
            r_nxt_buzy <= 1'b1;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == 4'd0) begin
            r_result  <= w_result;
            r_cdb_req <= 1'b1;
            r_state   <= S_WAIT_CDB;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_WAIT_CDB: begin
          // The result is dropped on the grant edge so the value bus idles at zero.
          if (cdb_grant) begin
            r_result   <= 32'd0;
            r_cdb_req  <= 1'b0;
            r_nxt_buzy <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_result   <= 32'd0;
          r_cdb_req  <= 1'b0;
          r_nxt_buzy <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign nxt_buzy       = r_nxt_buzy;
  assign cdb_req        = r_cdb_req;
  assign cdb_req_device = DEVICE_ID;
  assign cdb_req_value  = r_result;

endmodule

// File: tb/tb_exec_adder.sv
// tb/tb_exec_adder.sv - self-checking bench for exec_adder
// Table vectors, randomized ops against an arithmetic model, and reset/handshake sequences.

module tb_exec_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_buzy = 1'b0;
  logic        in_ready = 1'b0;
  logic [1:0]  in_algorithm = 2'd0;
  logic [35:0] in_valueA = 36'd0;
  logic [35:0] in_valueB = 36'd0;
  logic        cdb_grant = 1'b0;
  logic        nxt_buzy, cdb_req;
  logic [2:0]  cdb_req_device;
  logic [31:0] cdb_req_value;
  logic        nxt_buzy1, cdb_req1;
  logic [2:0]  cdb_req_device1;
  logic [31:0] cdb_req_value1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  exec_adder #(.LATENCY(2), .DEVICE_ID(3'd1)) dut (
    .clk(clk), .rst(rst), .in_buzy(in_buzy), .in_ready(in_ready),
    .in_algorithm(in_algorithm), .in_valueA(in_valueA), .in_valueB(in_valueB),
    .nxt_buzy(nxt_buzy), .cdb_grant(cdb_grant), .cdb_req(cdb_req),
    .cdb_req_device(cdb_req_device), .cdb_req_value(cdb_req_value)
  );

  exec_adder #(.LATENCY(1), .DEVICE_ID(3'd1)) dut1 (
    .clk(clk), .rst(rst), .in_buzy(in_buzy), .in_ready(in_ready),
    .in_algorithm(in_algorithm), .in_valueA(in_valueA), .in_valueB(in_valueB),
    .nxt_buzy(nxt_buzy1), .cdb_grant(cdb_grant), .cdb_req(cdb_req1),
    .cdb_req_device(cdb_req_device1), .cdb_req_value(cdb_req_value1)
  );

  typedef struct {
    logic [1:0]  alg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] ref_model(input logic [1:0] alg, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (alg)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return (sa < sb) ? 32'd1 : 32'd0;
      default: return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [1:0] alg, input logic [31:0] a, input logic [31:0] b);
    in_algorithm = alg;
    in_valueA    = {1'b1, 3'($urandom_range(7)), a};
    in_valueB    = {1'b1, 3'($urandom_range(7)), b};
    in_buzy      = 1'b1;
    in_ready     = 1'b1;
  endtask

  // Full transaction on the LATENCY=2 unit; grant either held high or withheld for wait_cyc cycles.
  task automatic do_op(input string tag, input logic [1:0] alg, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input int wait_cyc, input logic hold_grant);
    int lat;
    present(alg, a, b);
    cdb_grant = hold_grant;
    check({tag, ".pre_nxt_buzy"}, 32'(nxt_buzy), 32'd0);
    tick();
    // Garbage on the inputs while busy must not disturb the operation.
    in_algorithm = 2'($urandom_range(3));
    in_valueA    = {4'hF, 32'($urandom)};
    in_valueB    = {4'hF, 32'($urandom)};
    check({tag, ".nxt_buzy"}, 32'(nxt_buzy), 32'd1);
    lat = 0;
    while (!cdb_req && lat < 20) begin
      tick();
      lat++;
    end
    in_buzy  = 1'b0;
    in_ready = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'd2);
    check({tag, ".value"}, cdb_req_value, exp);
    check({tag, ".device"}, 32'(cdb_req_device), 32'd1);
    if (!hold_grant) begin
      for (int i = 0; i < wait_cyc; i++) begin
        tick();
        check({tag, ".hold_req"}, 32'(cdb_req), 32'd1);
        check({tag, ".hold_value"}, cdb_req_value, exp);
      end
      cdb_grant = 1'b1;
    end
    tick();
    cdb_grant = 1'b0;
    check({tag, ".post_req"}, 32'(cdb_req), 32'd0);
    check({tag, ".post_nxt_buzy"}, 32'(nxt_buzy), 32'd0);
    check({tag, ".post_value"}, cdb_req_value, 32'd0);
  endtask

  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst.nxt_buzy_async", 32'(nxt_buzy), 32'd0);
    check("rst.cdb_req_async", 32'(cdb_req), 32'd0);
    check("rst.value_async", cdb_req_value, 32'd0);
    #2;
    rst = 1'b0;
    in_buzy  = 1'b0;
    in_ready = 1'b0;
    cdb_grant = 1'b0;
    tick();
  endtask

  initial begin
    logic [1:0]  ra;
    logic [31:0] a, b;
    int lat;

    vecs[0] = '{2'd0, 32'd12345678, 32'd87654321, 32'd99999999};
    vecs[1] = '{2'd1, 32'd0, 32'd1, 32'hFFFF_FFFF};
    vecs[2] = '{2'd2, 32'hFFFF_FFFF, 32'd1, 32'd1};
    vecs[3] = '{2'd3, 32'hFFFF_FFFF, 32'd1, 32'd0};
    vecs[4] = '{2'd0, 32'hFFFF_FFFF, 32'd1, 32'd0};
    vecs[5] = '{2'd2, 32'd1, 32'hFFFF_FFFF, 32'd0};
    vecs[6] = '{2'd3, 32'd1, 32'hFFFF_FFFF, 32'd1};
    vecs[7] = '{2'd2, 32'h8000_0000, 32'h8000_0000, 32'd0};
    vecs[8] = '{2'd1, 32'd5, 32'd7, 32'hFFFF_FFFE};
    vecs[9] = '{2'd2, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1};

    #1 rst = 1'b1;
    #3;
    check("reset.nxt_buzy", 32'(nxt_buzy), 32'd0);
    check("reset.cdb_req", 32'(cdb_req), 32'd0);
    check("reset.value", cdb_req_value, 32'd0);
    check("reset.device", 32'(cdb_req_device), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), vecs[i].alg, vecs[i].a, vecs[i].b, vecs[i].exp, 0, 1'b1);

    do_op("grant_wait5", 2'd0, 32'd40, 32'd2, 32'd42, 5, 1'b0);

    // Entry valid but not ready: no accept until in_ready rises.
    in_buzy = 1'b1;
    in_ready = 1'b0;
    in_algorithm = 2'd1;
    in_valueA = {4'h0, 32'd999};
    in_valueB = {4'h0, 32'd111};
    for (int i = 0; i < 3; i++) begin
      tick();
      check("notready.nxt_buzy", 32'(nxt_buzy), 32'd0);
      check("notready.cdb_req", 32'(cdb_req), 32'd0);
    end
    do_op("notready.accept", 2'd0, 32'd7, 32'd8, 32'd15, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 2'($urandom_range(3));
      case ($urandom_range(3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = 32'($urandom_range(4)); b = 32'($urandom_range(4)); end
        2: begin a = $urandom; b = a; end
        default: begin a = {1'b1, 31'($urandom)}; b = {1'b0, 31'($urandom)}; end
      endcase
      if ($urandom_range(1) == 1) begin
        a = b;
        b = {~b[31], b[30:0]};
      end
      do_op($sformatf("rand%0d", i), ra, a, b, ref_model(ra, a, b),
            $urandom_range(3), 1'($urandom_range(1)));
    end

    // Reset mid-EXEC.
    present(2'd0, 32'd100, 32'd200);
    tick();
    in_buzy = 1'b0;
    in_ready = 1'b0;
    check("midexec.nxt_buzy", 32'(nxt_buzy), 32'd1);
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midexec.no_req", 32'(cdb_req), 32'd0);
    end
    do_op("after_rst_exec", 2'd0, 32'd1, 32'd1, 32'd2, 0, 1'b1);

    // Reset mid-WAIT_CDB.
    present(2'd1, 32'd50, 32'd8);
    cdb_grant = 1'b0;
    tick();
    in_buzy = 1'b0;
    in_ready = 1'b0;
    lat = 0;
    while (!cdb_req && lat < 20) begin
      tick();
      lat++;
    end
    check("midwait.req", 32'(cdb_req), 32'd1);
    check("midwait.value", cdb_req_value, 32'd42);
    pulse_reset();
    tick();
    check("midwait.no_req", 32'(cdb_req), 32'd0);
    do_op("after_rst_wait", 2'd0, 32'd1, 32'd1, 32'd2, 2, 1'b0);

    // LATENCY=1 build next to the LATENCY=2 build.
    pulse_reset();
    present(2'd0, 32'd1, 32'd1);
    cdb_grant = 1'b1;
    tick();
    in_buzy = 1'b0;
    in_ready = 1'b0;
    check("lat1.accept_req", 32'(cdb_req1), 32'd0);
    check("lat1.nxt_buzy", 32'(nxt_buzy1), 32'd1);
    tick();
    check("lat1.req", 32'(cdb_req1), 32'd1);
    check("lat1.value", cdb_req_value1, 32'd2);
    check("lat1.device", 32'(cdb_req_device1), 32'd1);
    check("lat2.not_yet", 32'(cdb_req), 32'd0);
    tick();
    check("lat1.done", 32'(cdb_req1), 32'd0);
    check("lat1.idle", 32'(nxt_buzy1), 32'd0);
    check("lat2.req", 32'(cdb_req), 32'd1);
    check("lat2.value", cdb_req_value, 32'd2);
    tick();
    cdb_grant = 1'b0;
    check("lat2.done", 32'(cdb_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exec_adder.md
Name: exec_adder

Overview:
- Integer adder functional unit; sits directly downstream of the adder reservation-station input buffer.
- Takes one ready instruction (algorithm plus two 36-bit tagged operands) from the buffer and computes it over a fixed number of cycles.
- Holds the result and requests the common data bus (CDB) until the CDB arbiter grants it.
- Drives the buffer's nxt_buzy input, so the buffer clears its entry on the accepting edge.

Parameters:
- LATENCY, 2, execute cycles between accept and the first CDB request; legal range 1..15.
- DEVICE_ID, 3'd1, device tag broadcast with the result; must equal `DEVICE_ADDER.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_buzy  input  1  buffer holds a valid entry (buffer out_buzy)
- in_ready  input  1  both operands of the entry are ready (buffer out_ready)
- in_algorithm  input  2  operation code (buffer out_algorithm)
- in_valueA  input  36  {ready, device[2:0], value[31:0]} (buffer out_valueA)
- in_valueB  input  36  same format as in_valueA (buffer out_valueB)
- nxt_buzy  output  1  unit cannot accept; drives buffer nxt_buzy
- cdb_grant  input  1  arbiter grants the CDB to this unit this cycle
- cdb_req  output  1  unit holds a result and requests the CDB
- cdb_req_device  output  3  tag broadcast with the result; always DEVICE_ID
- cdb_req_value  output  32  result value

Behaviour:
- States: IDLE, EXEC, WAIT_CDB. Encoding is free; the state is held in flops on the async reset.
- Reset (async, immediate):
  - state=IDLE, counter=0, result register=0.
  - nxt_buzy=0, cdb_req=0, cdb_req_value=0.
  - cdb_req_device=DEVICE_ID at all times.
- Reset in any state abandons the operation in flight. No partial result is ever broadcast.
- nxt_buzy = (state != IDLE). It is a pure function of state, with no combinational path from any input.
- Accept condition: state==IDLE && in_buzy && in_ready.
  - On that rising edge, latch in_algorithm, in_valueA[31:0] and in_valueB[31:0].
  - Load counter=LATENCY-1 and go to EXEC.
  - The ready and tag fields (bits 35:32) are ignored; in_ready already guarantees both ready bits are set.
- If in_buzy=1 and in_ready=0 in IDLE: stay in IDLE and keep nxt_buzy=0. Nothing is latched.
  - The buffer does not clear an entry that is not ready, so this is safe.
- EXEC:
  - Counter decrements each cycle.
  - When counter==0, register the computed result and go to WAIT_CDB.
  - Total: the first cycle with cdb_req=1 is exactly LATENCY cycles after the accept edge.
- Arithmetic is 32-bit and wrap-around; no overflow trap or flag.
  - `ADDER_ALGO_ADD=2'b00: A+B
  - `ADDER_ALGO_SUB=2'b01: A-B
  - `ADDER_ALGO_SLT=2'b10: {31'b0, signed(A)<signed(B)}
  - `ADDER_ALGO_SLTU=2'b11: {31'b0, A<B unsigned}
- WAIT_CDB:
  - cdb_req=1 and cdb_req_value=result, both stable until granted.
  - A cycle with cdb_grant=1 is the broadcast cycle; the next state is IDLE.
  - Without a grant the unit stays in WAIT_CDB indefinitely.
- cdb_grant is ignored in IDLE and EXEC.
- cdb_req_value reads 0 outside WAIT_CDB. It is not required to hold the stale result.
- After a grant the unit returns to IDLE. nxt_buzy=0 from that next cycle, so a new accept can occur at the earliest one cycle after the grant edge.
  - Minimum issue interval is LATENCY+2 cycles.
- Inputs changing while state != IDLE have no effect.

Test Plan:
- Reset, then ADD A=12345678, B=87654321, in_buzy=in_ready=1, cdb_grant=1 held:
  - nxt_buzy rises the cycle after accept.
  - cdb_req=1 with value 99999999 (decimal) exactly 2 cycles after accept.
  - Back to IDLE the next cycle.
- SUB A=0, B=1 -> result 32'hFFFFFFFF.
- SLT A=32'hFFFFFFFF, B=1 -> 1; SLTU with the same operands -> 0.
- Hold cdb_grant=0 for 5 cycles in WAIT_CDB -> cdb_req and cdb_req_value stay constant.
  - Grant in cycle 6 -> IDLE next cycle.
- in_buzy=1, in_ready=0 for 3 cycles -> nxt_buzy stays 0 and there is no accept.
  - Raise in_ready -> accept on the next edge.
- Assert rst mid-EXEC and mid-WAIT_CDB:
  - cdb_req and nxt_buzy drop immediately, before the next clock edge.
  - After rst is released, a new ADD of 1+1 returns 2.
  - LATENCY=1 build: same ADD gives cdb_req 1 cycle after accept.
